// File: rtl/kanagawa_backoff_pkg.sv
// Shared types and helpers for the kanagawa randomized exponential-backoff block.
// Used by kanagawa_lfsr_backoff and kanagawa_backoff_counter.
package kanagawa_backoff_pkg;

  // Controller states: waiting for an outcome, counting a delay, offering a retry.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } backoff_state_e;

  // Width of the optional statistics counters.
  localparam int unsigned STAT_W = 32;

  // Window mask for a given exponent: the low 'e' bits set, i.e. 2^e - 1.
  function automatic logic [31:0] window_mask(input logic [31:0] e);
    return (32'd1 << e) - 32'd1;
  endfunction

endpackage

// File: rtl/kanagawa_backoff_counter.sv
// Loadable down counter holding the remaining backoff delay.
// load has priority over dec; dec stops at zero; zero flags an empty count.
module kanagawa_backoff_counter
  import kanagawa_backoff_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value;

  // Delay register: load a fresh draw, otherwise count down toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/kanagawa_lfsr_backoff.sv
// Randomized exponential-backoff controller for runtime retry paths.
// Each failure draws a delay from the shared LFSR, masked by a window that doubles
// per consecutive failure (capped at 2^MAX_EXP-1), then offers a retry token.
// Optional statistics counters are enabled by defining KANAGAWA_BACKOFF_STATS_EN.
//
// Handshake: retry_valid is a pure decode of the GRANT state; once high it stays
// high until a cycle where retry_valid and retry_ready are both high (transfer),
// except that success or reset withdraw it.
module kanagawa_lfsr_backoff
  import kanagawa_backoff_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH   = 11,
  parameter int unsigned MAX_EXP      = 10,
  parameter int unsigned MAX_ATTEMPTS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LFSR_WIDTH-1:0] lfsr_in,
  output logic                  lfsr_en,
  input  logic                  fail_valid,
  input  logic                  success,
  output logic                  retry_valid,
  input  logic                  retry_ready,
  output logic                  give_up,
  output logic                  busy
`ifdef KANAGAWA_BACKOFF_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_draws,
  output logic [STAT_W-1:0]     stat_wait_cycles
`endif
);

  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned EXP_W = $clog2(MAX_EXP + 1);

  backoff_state_e   state;
  logic [EXP_W-1:0] exp_q;
  logic [ATT_W-1:0] attempts_q;

  logic [EXP_W-1:0]   exp_next;
  logic [MAX_EXP-1:0] draw_value;
  logic               room;
  logic               fail_idle;
  logic               count_zero;
  logic               count_load;
  logic [MAX_EXP-1:0] count_load_value;
  logic               count_dec;

  // Next exponent saturates at MAX_EXP so the window never exceeds 2^MAX_EXP-1.
  assign exp_next = (exp_q == EXP_W'(MAX_EXP)) ? exp_q : exp_q + EXP_W'(1);

  // Draw: mask the LFSR word with the new window; the mask never reaches above MAX_EXP bits.
  assign draw_value = MAX_EXP'(lfsr_in & LFSR_WIDTH'(window_mask(32'(exp_next))));

  assign room      = (attempts_q < ATT_W'(MAX_ATTEMPTS));
  // success outranks a simultaneous failure report, so neither strobe fires then.
  assign fail_idle = (state == IDLE) && fail_valid && !success;
  assign lfsr_en   = fail_idle && room;
  assign give_up   = fail_idle && !room;

  assign retry_valid = (state == GRANT);
  assign busy        = (state != IDLE);

  // The delay counter is loaded with a draw, or cleared by success.
  assign count_load       = lfsr_en || success;
  assign count_load_value = success ? '0 : draw_value;
  assign count_dec        = (state == WAIT);

  kanagawa_backoff_counter #(
    .W (MAX_EXP)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (count_load),
    .load_value (count_load_value),
    .dec        (count_dec),
    .zero       (count_zero)
  );

  // Backoff FSM with exponent and attempt history; success clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_q      <= '0;
      attempts_q <= '0;
    end else if (success) begin
      state      <= IDLE;
      exp_q      <= '0;
      attempts_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fail_valid) begin
            if (room) begin
              exp_q      <= exp_next;
              attempts_q <= attempts_q + ATT_W'(1);
              state      <= WAIT;
            end else begin
              exp_q      <= '0;
              attempts_q <= '0;
            end
          end
        end
        WAIT: begin
          if (count_zero) state <= GRANT;
        end
        GRANT: begin
          if (retry_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KANAGAWA_BACKOFF_STATS_EN
  // Saturating usage statistics; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_draws       <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (lfsr_en && (stat_draws != '1)) stat_draws <= stat_draws + STAT_W'(1);
      if ((state == WAIT) && (stat_wait_cycles != '1))
        stat_wait_cycles <= stat_wait_cycles + STAT_W'(1);
    end
  end
`endif

  // A failure may only be reported while idle; elsewhere it is ignored.
  assert property (@(posedge clk) disable iff (!rst_n) !(fail_valid && (state != IDLE)));

endmodule

// File: tb/tb_kanagawa_lfsr_backoff.sv
// Directed bench for kanagawa_lfsr_backoff: table-driven fail/retry vectors plus
// hand-written sequences for give-up, success and asynchronous reset.
module tb_kanagawa_lfsr_backoff;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] lfsr_in = '0;
  logic        fail_valid = 1'b0;
  logic        success = 1'b0;
  logic        retry_ready = 1'b0;
  logic        lfsr_en, retry_valid, give_up, busy;
`ifdef KANAGAWA_BACKOFF_STATS_EN
  logic [31:0] stat_draws, stat_wait_cycles;
`endif

  always #5 clk = ~clk;

  kanagawa_lfsr_backoff dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lfsr_in     (lfsr_in),
    .lfsr_en     (lfsr_en),
    .fail_valid  (fail_valid),
    .success     (success),
    .retry_valid (retry_valid),
    .retry_ready (retry_ready),
    .give_up     (give_up),
    .busy        (busy)
`ifdef KANAGAWA_BACKOFF_STATS_EN
    ,
    .stat_draws       (stat_draws),
    .stat_wait_cycles (stat_wait_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int exp_draws = 0;
  int exp_waits = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: report a failure, measure retry latency, then handshake.
  task automatic run_attempt(input string name, input logic [10:0] lfsr, input int d,
                             input int hold);
    int n;
    logic [31:0] lat;
    fail_valid = 1'b1;
    lfsr_in    = lfsr;
    exp_q.push_back(32'(d + 2));
    @(negedge clk);
    chk({name, "_lfsr_en"}, 32'(lfsr_en), 1);
    chk({name, "_give_up"}, 32'(give_up), 0);
    @(posedge clk); #1;
    fail_valid = 1'b0;
    n = 1;
    while (!retry_valid && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = exp_q.pop_front();
    chk({name, "_latency"}, 32'(n), lat);
    exp_draws++;
    exp_waits += d + 1;
    for (int i = 0; i < hold; i++) begin
      chk({name, "_hold_valid"}, 32'(retry_valid), 1);
      @(posedge clk); #1;
    end
    retry_ready = 1'b1;
    @(negedge clk);
    chk({name, "_grant_valid"}, 32'(retry_valid), 1);
    @(posedge clk); #1;
    retry_ready = 1'b0;
    chk({name, "_busy_after"}, 32'(busy), 0);
    chk({name, "_valid_after"}, 32'(retry_valid), 0);
  endtask

  task automatic pulse_success();
    success = 1'b1;
    @(posedge clk); #1;
    success = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          pre_success;
    logic [10:0] lfsr;
    int          d;
    int          hold;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b0, 11'h5A3, 1, 0};
    vecs[1]  = '{1'b1, 11'h7FF, 1, 0};
    vecs[2]  = '{1'b0, 11'h7FF, 3, 0};
    vecs[3]  = '{1'b0, 11'h7FF, 7, 0};
    vecs[4]  = '{1'b0, 11'h7FF, 15, 0};
    vecs[5]  = '{1'b0, 11'h7FF, 31, 5};
    vecs[6]  = '{1'b0, 11'h7FF, 63, 0};
    vecs[7]  = '{1'b0, 11'h7FF, 127, 0};
    vecs[8]  = '{1'b0, 11'h7FF, 255, 0};
    vecs[9]  = '{1'b0, 11'h7FF, 511, 0};
    vecs[10] = '{1'b0, 11'h7FF, 1023, 0};
    vecs[11] = '{1'b0, 11'h7FF, 1023, 0};
    vecs[12] = '{1'b1, 11'h2B6, 0, 0};
    vecs[13] = '{1'b0, 11'h2B6, 2, 0};
    vecs[14] = '{1'b0, 11'h2B6, 6, 0};
    vecs[15] = '{1'b0, 11'h4D9, 9, 2};
    vecs[16] = '{1'b0, 11'h7E0, 0, 0};

    // reset state
    #3;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_retry_valid", 32'(retry_valid), 0);
    chk("reset_lfsr_en", 32'(lfsr_en), 0);
    chk("reset_give_up", 32'(give_up), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven fail/retry rounds
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].pre_success) pulse_success();
      run_attempt($sformatf("row%0d", i), vecs[i].lfsr, vecs[i].d, vecs[i].hold);
    end

    // fill the attempt budget (5 used) with zero-delay draws
    for (int i = 0; i < 11; i++) run_attempt($sformatf("fill%0d", i), 11'h000, 0, 0);

    // 17th consecutive failure gives up without drawing
    fail_valid = 1'b1;
    lfsr_in    = 11'h7FF;
    @(negedge clk);
    chk("give_up_pulse", 32'(give_up), 1);
    chk("give_up_no_draw", 32'(lfsr_en), 0);
    @(posedge clk); #1;
    fail_valid = 1'b0;
    chk("give_up_no_wait", 32'(busy), 0);
    @(negedge clk);
    chk("give_up_one_cycle", 32'(give_up), 0);
    @(posedge clk); #1;
    run_attempt("after_give_up", 11'h7FF, 1, 0);

    // success during WAIT withdraws the pending retry and clears history
    fail_valid = 1'b1;
    lfsr_in    = 11'h7FF;
    @(negedge clk);
    chk("sw_draw", 32'(lfsr_en), 1);
    @(posedge clk); #1;
    fail_valid = 1'b0;
    chk("sw_busy_wait", 32'(busy), 1);
    success = 1'b1;
    @(negedge clk);
    chk("sw_no_draw", 32'(lfsr_en), 0);
    @(posedge clk); #1;
    success = 1'b0;
    exp_draws++;
    exp_waits += 1;
    for (int i = 0; i < 6; i++) begin
      chk("sw_idle_busy", 32'(busy), 0);
      chk("sw_idle_valid", 32'(retry_valid), 0);
      @(posedge clk); #1;
    end
    run_attempt("sw_exp_cleared", 11'h7FF, 1, 0);

    // success together with fail_valid in IDLE: no draw, history cleared
    fail_valid = 1'b1;
    success    = 1'b1;
    lfsr_in    = 11'h7FF;
    @(negedge clk);
    chk("sf_no_draw", 32'(lfsr_en), 0);
    chk("sf_no_give_up", 32'(give_up), 0);
    @(posedge clk); #1;
    fail_valid = 1'b0;
    success    = 1'b0;
    chk("sf_busy", 32'(busy), 0);
    chk("sf_valid", 32'(retry_valid), 0);
    run_attempt("sf_exp_cleared", 11'h7FF, 1, 0);

`ifdef KANAGAWA_BACKOFF_STATS_EN
    chk("stat_draws", stat_draws, 32'(exp_draws));
    chk("stat_wait_cycles", stat_wait_cycles, 32'(exp_waits));
`endif

    // asynchronous reset in the middle of WAIT
    fail_valid = 1'b1;
    lfsr_in    = 11'h7FF;
    @(posedge clk); #1;
    fail_valid = 1'b0;
    chk("rw_busy_wait", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_valid", 32'(retry_valid), 0);
    chk("rw_lfsr_en", 32'(lfsr_en), 0);
    chk("rw_give_up", 32'(give_up), 0);
`ifdef KANAGAWA_BACKOFF_STATS_EN
    chk("rw_stat_draws", stat_draws, 0);
    chk("rw_stat_waits", stat_wait_cycles, 0);
`endif
    exp_draws = 0;
    exp_waits = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rw_no_retry", 32'(retry_valid), 0);
    end
    run_attempt("after_reset", 11'h7FF, 1, 0);
`ifdef KANAGAWA_BACKOFF_STATS_EN
    chk("post_stat_draws", stat_draws, 32'(exp_draws));
    chk("post_stat_waits", stat_wait_cycles, 32'(exp_waits));
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
